// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder and the decode path:
// instruction kinds, opcode values, field bit positions and encoder states.
package instr_encoder_pkg;

   // Descriptor kinds; codes 13-15 are illegal
   typedef enum logic [3:0] {
      KIND_RTYPE = 4'd0,
      KIND_J     = 4'd1,
      KIND_JAL   = 4'd2,
      KIND_BEQ   = 4'd3,
      KIND_BNE   = 4'd4,
      KIND_ADDI  = 4'd5,
      KIND_ADDIU = 4'd6,
      KIND_SLTI  = 4'd7,
      KIND_ANDI  = 4'd8,
      KIND_ORI   = 4'd9,
      KIND_COP0  = 4'd10,
      KIND_LW    = 4'd11,
      KIND_SW    = 4'd12
   } kind_e;

   // Primary opcode values (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_COP0  = 6'b010000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // Field positions and widths inside a 32-bit instruction word
   localparam int unsigned OP_LSB     = 26;
   localparam int unsigned OP_W       = 6;
   localparam int unsigned RS_LSB     = 21;
   localparam int unsigned RT_LSB     = 16;
   localparam int unsigned RD_LSB     = 11;
   localparam int unsigned SHAMT_LSB  = 6;
   localparam int unsigned REG_W      = 5;
   localparam int unsigned FUNCT_LSB  = 0;
   localparam int unsigned FUNCT_W    = 6;
   localparam int unsigned IMM_LSB    = 0;
   localparam int unsigned IMM_W      = 16;
   localparam int unsigned TARGET_LSB = 0;
   localparam int unsigned TARGET_W   = 26;

   // Encoder session states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_FULL = 2'd2;

   // Raw instruction fields carried with a descriptor
   typedef struct packed {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] target;
   } instr_fields_t;

   // Opcode for a kind; illegal kinds map to zero
   function automatic logic [5:0] opcode_of(input logic [3:0] kind);
      case (kind)
         KIND_RTYPE: return OP_RTYPE;
         KIND_J:     return OP_J;
         KIND_JAL:   return OP_JAL;
         KIND_BEQ:   return OP_BEQ;
         KIND_BNE:   return OP_BNE;
         KIND_ADDI:  return OP_ADDI;
         KIND_ADDIU: return OP_ADDIU;
         KIND_SLTI:  return OP_SLTI;
         KIND_ANDI:  return OP_ANDI;
         KIND_ORI:   return OP_ORI;
         KIND_COP0:  return OP_COP0;
         KIND_LW:    return OP_LW;
         KIND_SW:    return OP_SW;
         default:    return 6'b000000;
      endcase
   endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational packer from instruction kind plus raw fields to a
// 32-bit MIPS word, with an illegal-kind flag.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [3:0]    kind_i,
   input  instr_fields_t fields_i,
   output logic [31:0]   word_o,
   output logic          illegal_o
);

   logic [5:0] op;

   assign op = opcode_of(kind_i);

   // Place each field for the word format of the kind; unknown kinds give zero
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      word_o    = '0;
      illegal_o = 1'b0;
      case (kind_i)
         KIND_RTYPE: begin
            word_o[OP_LSB    +: OP_W]    = op;
            word_o[RS_LSB    +: REG_W]   = fields_i.rs;
            word_o[RT_LSB    +: REG_W]   = fields_i.rt;
            word_o[RD_LSB    +: REG_W]   = fields_i.rd;
            word_o[SHAMT_LSB +: REG_W]   = fields_i.shamt;
            word_o[FUNCT_LSB +: FUNCT_W] = fields_i.funct;
         end
         KIND_J, KIND_JAL: begin
            word_o[OP_LSB     +: OP_W]     = op;
            word_o[TARGET_LSB +: TARGET_W] = fields_i.target;
         end
         KIND_COP0: begin
            word_o[OP_LSB +: OP_W]  = op;
            word_o[RS_LSB +: REG_W] = fields_i.rs;
            word_o[RT_LSB +: REG_W] = fields_i.rt;
            word_o[RD_LSB +: REG_W] = fields_i.rd;
         end
         KIND_BEQ, KIND_BNE, KIND_ADDI, KIND_ADDIU, KIND_SLTI,
         KIND_ANDI, KIND_ORI, KIND_LW, KIND_SW: begin
            word_o[OP_LSB  +: OP_W]  = op;
            word_o[RS_LSB  +: REG_W] = fields_i.rs;
            word_o[RT_LSB  +: REG_W] = fields_i.rt;
            word_o[IMM_LSB +: IMM_W] = fields_i.imm;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction descriptors over valid/ready, packs them
// into MIPS words and writes them sequentially into instruction memory.
// Optional feature macro: INSTR_ENC_CHECKSUM_EN enables the running XOR
// checksum of written words; otherwise the checksum port is tied to zero.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       checksum
);

   localparam int unsigned       DEPTH    = 2 ** ADDR_W;
   // Base address reduced modulo DEPTH
   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] next_addr_q, next_addr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              done_q, done_d;

   instr_fields_t     fields;
   logic [31:0]       word;
   logic              illegal;
   logic              accept;
   logic              write;

   assign fields = '{rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                     funct: in_funct, imm: in_imm, target: in_target};

   instr_pack u_pack (
      .kind_i    (in_kind),
      .fields_i  (fields),
      .word_o    (word),
      .illegal_o (illegal)
   );

   // A beat offered alongside start/finish is not taken
   assign busy     = (state_q == ST_LOAD) || (state_q == ST_FULL);
   assign in_ready = (state_q == ST_LOAD) && !start && !finish;
   assign accept   = in_ready && in_valid;
   assign write    = accept && !illegal;

   // Next-state: write register, counters, error flag and session FSM
   always_comb begin
      state_d     = state_q;
      next_addr_d = next_addr_q;
      count_d     = count_q;
      err_d       = err_q;
      we_d        = write;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      done_d      = 1'b0;

      if (write) begin
         addr_d      = next_addr_q;
         wdata_d     = word;
         next_addr_d = next_addr_q + ADDR_ONE;
         count_d     = count_q + CNT_ONE;
      end
      if (accept && illegal) begin
         err_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: ;
         ST_LOAD: if (write && (count_q == CNT_LAST)) state_d = ST_FULL;
         ST_FULL: ;
         default: state_d = ST_IDLE;
      endcase

      // start wins over finish and reopens a session from any state
      if (start) begin
         state_d     = ST_LOAD;
         next_addr_d = BASE_A;
         count_d     = '0;
         err_d       = 1'b0;
      end else if (finish && busy) begin
         state_d = ST_IDLE;
         done_d  = 1'b1;
      end
   end

   // State registers; reset aborts any session and drops a pending write
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         next_addr_q <= BASE_A;
         count_q     <= '0;
         err_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         next_addr_q <= next_addr_d;
         count_q     <= count_d;
         err_q       <= err_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         done_q      <= done_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign count     = count_q;
   assign done      = done_q;
   assign err       = err_q;

`ifdef INSTR_ENC_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   // Fold each written word into the running XOR; start clears it
   always_comb begin
      checksum_d = checksum_q;
      if (write) checksum_d = checksum_q ^ word;
      if (start) checksum_d = '0;
   end

   // Checksum register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) checksum_q <= '0;
      else        checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. Two instances share the stimulus:
// a 4-word memory at base 0 and an 8-word memory at base 5 (address wrap).
// Honours INSTR_ENC_CHECKSUM_EN when computing expected checksums.
module tb_instr_encoder;

   typedef struct {
      logic [3:0]  kind;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] target;
   } desc_t;

   typedef struct {
      desc_t       d;
      logic [31:0] word;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [31:0] ready, we, addr, wdata, cnt, busy, done, err, chk;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0;
   logic [3:0]  in_kind = '0;
   logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
   logic [5:0]  in_funct = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_target = '0;

   logic        a_ready, a_we, a_busy, a_done, a_err;
   logic [1:0]  a_addr;
   logic [2:0]  a_count;
   logic [31:0] a_wdata, a_chk;
   logic        b_ready, b_we, b_busy, b_done, b_err;
   logic [2:0]  b_addr;
   logic [3:0]  b_count;
   logic [31:0] b_wdata, b_chk;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(a_ready), .in_kind(in_kind),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
      .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .count(a_count),
      .busy(a_busy), .done(a_done), .err(a_err), .checksum(a_chk)
   );

   instr_encoder #(.ADDR_W(3), .BASE_ADDR(5)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(b_ready), .in_kind(in_kind),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
      .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .count(b_count),
      .busy(b_busy), .done(b_done), .err(b_err), .checksum(b_chk)
   );

   // ---------------- reference model ----------------
   int          depth [2] = '{4, 8};
   int          base  [2] = '{0, 5};
   int          op_tab [13] = '{0, 2, 3, 4, 5, 8, 9, 10, 12, 13, 16, 35, 43};
   bit          m_open [2];
   int          m_count [2];
   bit          m_err [2];
   bit          m_we [2];
   bit          m_done [2];
   int          m_addr [2];
   logic [31:0] m_wdata [2];
   logic [31:0] m_chk [2];

   function automatic logic [31:0] ref_word(input desc_t d);
      longint w;
      int     k = int'(d.kind);
      if (k > 12) return 32'h0;
      w = longint'(op_tab[k]) * 64'd67108864;
      if (k == 0)
         w += longint'(d.rs) * 2097152 + longint'(d.rt) * 65536 + longint'(d.rd) * 2048
              + longint'(d.shamt) * 64 + longint'(d.funct);
      else if (k == 1 || k == 2)
         w += longint'(d.target);
      else if (k == 10)
         w += longint'(d.rs) * 2097152 + longint'(d.rt) * 65536 + longint'(d.rd) * 2048;
      else
         w += longint'(d.rs) * 2097152 + longint'(d.rt) * 65536 + longint'(d.imm);
      return w[31:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_open[i] = 0; m_count[i] = 0; m_err[i] = 0; m_we[i] = 0;
         m_done[i] = 0; m_addr[i] = 0; m_wdata[i] = '0; m_chk[i] = '0;
      end
   endtask

   function automatic bit model_ready(input int i, input logic s, input logic f);
      return m_open[i] && (m_count[i] < depth[i]) && !s && !f;
   endfunction

   task automatic model_step(input int i, input logic s, input logic f, input logic v, input desc_t d);
      bit acc = model_ready(i, s, f) && v;
      bit ill = d.kind > 4'd12;
      m_we[i]   = 0;
      m_done[i] = 0;
      if (acc && !ill) begin
         m_we[i]    = 1;
         m_addr[i]  = (base[i] + m_count[i]) % depth[i];
         m_wdata[i] = ref_word(d);
         m_count[i] = m_count[i] + 1;
`ifdef INSTR_ENC_CHECKSUM_EN
         m_chk[i] = m_chk[i] ^ m_wdata[i];
`endif
      end
      if (acc && ill) m_err[i] = 1;
      if (s) begin
         m_open[i] = 1; m_count[i] = 0; m_err[i] = 0; m_chk[i] = '0;
      end else if (f && m_open[i]) begin
         m_open[i] = 0; m_done[i] = 1;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic obs_t observe(input int i);
      obs_t o;
      if (i == 0) begin
         o.ready = 32'(a_ready); o.we = 32'(a_we); o.addr = 32'(a_addr); o.wdata = a_wdata;
         o.cnt = 32'(a_count); o.busy = 32'(a_busy); o.done = 32'(a_done);
         o.err = 32'(a_err); o.chk = a_chk;
      end else begin
         o.ready = 32'(b_ready); o.we = 32'(b_we); o.addr = 32'(b_addr); o.wdata = b_wdata;
         o.cnt = 32'(b_count); o.busy = 32'(b_busy); o.done = 32'(b_done);
         o.err = 32'(b_err); o.chk = b_chk;
      end
      return o;
   endfunction

   task automatic check_outputs(input int i);
      obs_t  o = observe(i);
      string p = (i == 0) ? "a" : "b";
      check({p, ".mem_we"}, o.we, 32'(m_we[i]));
      check({p, ".mem_addr"}, o.addr, 32'(m_addr[i]));
      check({p, ".mem_wdata"}, o.wdata, m_wdata[i]);
      check({p, ".count"}, o.cnt, 32'(m_count[i]));
      check({p, ".busy"}, o.busy, 32'(m_open[i]));
      check({p, ".done"}, o.done, 32'(m_done[i]));
      check({p, ".err"}, o.err, 32'(m_err[i]));
      check({p, ".checksum"}, o.chk, m_chk[i]);
   endtask

   function automatic desc_t mk(input int k, input int rs, input int rt, input int rd,
                                input int sh, input int fn, input int imm, input int tg);
      desc_t d;
      d.kind = 4'(k); d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd); d.shamt = 5'(sh);
      d.funct = 6'(fn); d.imm = 16'(imm); d.target = 26'(tg);
      return d;
   endfunction

   // One clock cycle: drive after negedge, check ready, clock, check outputs
   task automatic cycle(input logic s, input logic f, input logic v, input desc_t d);
      start = s; finish = f; in_valid = v; in_kind = d.kind;
      in_rs = d.rs; in_rt = d.rt; in_rd = d.rd; in_shamt = d.shamt;
      in_funct = d.funct; in_imm = d.imm; in_target = d.target;
      #1;
      for (int i = 0; i < 2; i++) begin
         obs_t o = observe(i);
         check((i == 0) ? "a.in_ready" : "b.in_ready", o.ready, 32'(model_ready(i, s, f)));
         model_step(i, s, f, v, d);
      end
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) check_outputs(i);
   endtask

   // ---------------- stimulus ----------------
   vec_t        vecs [15];
   desc_t       nop;
   logic [31:0] exp_chk;
   int          wr;

   initial begin
      nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
      vecs[0]  = '{mk(5, 1, 2, 0, 0, 0, 16'h0005, 0), 32'h20220005, 1'b0};
      vecs[1]  = '{mk(0, 0, 1, 2, 3, 0, 16'hFFFF, 26'h3FFFFFF), 32'h000110C0, 1'b0};
      vecs[2]  = '{mk(1, 31, 31, 31, 31, 63, 16'hFFFF, 26'h3FFFFFF), 32'h0BFFFFFF, 1'b0};
      vecs[3]  = '{mk(2, 0, 0, 0, 0, 0, 0, 26'h0000010), 32'h0C000010, 1'b0};
      vecs[4]  = '{mk(3, 3, 4, 31, 0, 0, 16'hFFFF, 0), 32'h1064FFFF, 1'b0};
      vecs[5]  = '{mk(4, 31, 31, 0, 0, 0, 16'h1234, 0), 32'h17FF1234, 1'b0};
      vecs[6]  = '{mk(6, 0, 0, 0, 0, 0, 16'h8000, 0), 32'h24008000, 1'b0};
      vecs[7]  = '{mk(7, 5, 6, 0, 0, 0, 16'h0001, 0), 32'h28A60001, 1'b0};
      vecs[8]  = '{mk(8, 7, 1, 0, 0, 0, 16'h00FF, 0), 32'h30E100FF, 1'b0};
      vecs[9]  = '{mk(9, 2, 3, 0, 0, 0, 16'hABCD, 0), 32'h3443ABCD, 1'b0};
      vecs[10] = '{mk(10, 4, 9, 12, 31, 63, 16'hFFFF, 26'h3FFFFFF), 32'h40896000, 1'b0};
      vecs[11] = '{mk(11, 29, 8, 0, 0, 0, 16'h0004, 0), 32'h8FA80004, 1'b0};
      vecs[12] = '{mk(12, 29, 31, 0, 0, 0, 16'hFFFC, 0), 32'hAFBFFFFC, 1'b0};
      vecs[13] = '{mk(13, 1, 2, 3, 4, 5, 16'h1111, 0), 32'h0, 1'b1};
      vecs[14] = '{mk(15, 1, 2, 3, 4, 5, 16'h2222, 0), 32'h0, 1'b1};

      // Reset values
      model_reset();
      repeat (2) @(negedge clk);
      check("reset.a.in_ready", 32'(a_ready), 32'h0);
      for (int i = 0; i < 2; i++) check_outputs(i);
      rst_n = 1'b1;

      // ADDI then RTYPE in one session; checksum of the two words
      cycle(1, 0, 0, nop);
      cycle(0, 0, 1, vecs[0].d);
      check("addi.we", 32'(a_we), 32'h1);
      check("addi.addr", 32'(a_addr), 32'h0);
      check("addi.wdata", a_wdata, 32'h20220005);
      check("addi.count", 32'(a_count), 32'h1);
      cycle(0, 0, 1, mk(0, 1, 2, 3, 0, 6'h20, 0, 0));
      check("rtype.wdata", a_wdata, 32'h00221820);
`ifdef INSTR_ENC_CHECKSUM_EN
      exp_chk = 32'h20001825;   // 0x20220005 ^ 0x00221820
`else
      exp_chk = 32'h0;
`endif
      check("checksum.two_words", a_chk, exp_chk);

      // RTYPE then JAL back-to-back from a fresh session
      cycle(1, 0, 0, nop);
      cycle(0, 0, 1, mk(0, 1, 2, 3, 0, 6'h20, 0, 0));
      check("b2b.first.addr", 32'(a_addr), 32'h0);
      check("b2b.first.wdata", a_wdata, 32'h00221820);
      cycle(0, 0, 1, vecs[3].d);
      check("b2b.second.we", 32'(a_we), 32'h1);
      check("b2b.second.addr", 32'(a_addr), 32'h1);
      check("b2b.second.wdata", a_wdata, 32'h0C000010);

      // LW, then an illegal kind, then a restart
      cycle(1, 0, 0, nop);
      cycle(0, 0, 1, vecs[11].d);
      check("lw.wdata", a_wdata, 32'h8FA80004);
      cycle(0, 0, 1, mk(14, 1, 1, 1, 1, 1, 1, 1));
      check("illegal.err", 32'(a_err), 32'h1);
      check("illegal.we", 32'(a_we), 32'h0);
      check("illegal.count", 32'(a_count), 32'h1);
      cycle(1, 0, 0, nop);
      check("restart.err", 32'(a_err), 32'h0);
      check("restart.count", 32'(a_count), 32'h0);

      // Encoding table: each vector in its own session
      for (int v = 0; v < 15; v++) begin
         cycle(1, 0, 0, nop);
         cycle(0, 0, 1, vecs[v].d);
         check($sformatf("table[%0d].we", v), 32'(a_we), 32'(!vecs[v].ill));
         if (!vecs[v].ill) check($sformatf("table[%0d].word", v), a_wdata, vecs[v].word);
         check($sformatf("table[%0d].err", v), 32'(a_err), 32'(vecs[v].ill));
      end

      // start while a write is in flight: write completes, then counters clear
      cycle(1, 0, 0, nop);
      cycle(0, 0, 1, vecs[0].d);
      check("inflight.we", 32'(a_we), 32'h1);
      check("inflight.count", 32'(a_count), 32'h1);
      cycle(1, 0, 1, vecs[4].d);
      check("inflight.cleared", 32'(a_count), 32'h0);
      check("inflight.addr_held", 32'(a_addr), 32'h0);

      // Fill the 4-word memory with valid held for 6 cycles, then finish
      cycle(1, 0, 0, nop);
      wr = 0;
      for (int c = 0; c < 6; c++) begin
         cycle(0, 0, 1, mk(5, c, c + 1, 0, 0, 0, c, 0));
         if (a_we) wr++;
      end
      check("full.writes", 32'(wr), 32'd4);
      check("full.last_addr", 32'(a_addr), 32'd3);
      check("full.count", 32'(a_count), 32'd4);
      check("full.busy", 32'(a_busy), 32'h1);
      cycle(0, 1, 1, nop);
      check("full.done", 32'(a_done), 32'h1);
      check("full.idle", 32'(a_busy), 32'h0);
      cycle(0, 0, 0, nop);
      check("full.done_pulse", 32'(a_done), 32'h0);

      // Reset in the cycle after an accept drops the write
      cycle(1, 0, 0, nop);
      cycle(0, 0, 1, vecs[5].d);
      start = 0; finish = 0; in_valid = 0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("reset_mid.a.in_ready", 32'(a_ready), 32'h0);
      for (int i = 0; i < 2; i++) check_outputs(i);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) check_outputs(i);
      rst_n = 1'b1;

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         logic  s = ($urandom % 32) == 0;
         logic  f = ($urandom % 48) == 0;
         logic  v = ($urandom % 10) < 7;
         int    k = (($urandom % 12) == 0) ? 13 + int'($urandom % 3) : int'($urandom % 13);
         cycle(s, f, v, mk(k, $urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
